// File: rtl/rx_engine_stream.sv
// rtl/rx_engine_stream.sv - receive-side Ethernet engine: preamble strip, address/type filter, FCS check, payload stream
//
// Ports:
//   clk, reset_n            receive byte clock, asynchronous active-low reset
//   local_mac_addr          accepted unicast destination (broadcast always accepted)
//   ethertype               accepted ethertype
//   promiscuous             1 = accept any destination
//   jumboframes             1 = MAX_JUMBO length limit, 0 = MAX_STD
//   int_rx_din/dv/er        byte stream from the reconciliation layer
//   rxd_data/valid/sof      payload byte stream (FCS never emitted)
//   rxd_eof/err             one-cycle status beat per accepted frame
//   rx_count/rx_err_count   good / bad accepted-frame counters
module rx_engine_stream #(
    parameter int MAX_STD   = 1518,
    parameter int MAX_JUMBO = 9018,
    parameter int MIN_LEN   = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [47:0] local_mac_addr,
    input  logic [15:0] ethertype,
    input  logic        promiscuous,
    input  logic        jumboframes,
    input  logic [7:0]  int_rx_din,
    input  logic        int_rx_dv,
    input  logic        int_rx_er,
    output logic [7:0]  rxd_data,
    output logic        rxd_valid,
    output logic        rxd_sof,
    output logic        rxd_eof,
    output logic        rxd_err,
    output logic [31:0] rx_count,
    output logic [31:0] rx_err_count
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, DROP} state_t;

    localparam logic [13:0] MIN_L = 14'(MIN_LEN);
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] bit_rev(input logic [31:0] c);
        logic [31:0] r;
        for (int i = 0; i < 32; i++)
            r[i] = c[31-i];
        return r;
    endfunction

    state_t          state;
    logic [7:0]      din_q;
    logic            dv_q, er_q, dv_prev;
    logic [31:0]     crc;
    logic [13:0]     len;
    logic [39:0]     hdr;
    logic [3:0][7:0] dl;
    logic [2:0]      dl_cnt;
    logic            sof_pend;
    logic            er_seen;

    logic [13:0] len_next, max_len;
    logic [47:0] dst_word;
    logic [15:0] type_word;
    logic [31:0] crc_next;
    logic        frame_bad;

    always_comb begin
        len_next  = (len == 14'h3FFF) ? len : len + 14'd1;
        max_len   = jumboframes ? 14'(MAX_JUMBO) : 14'(MAX_STD);
        dst_word  = {hdr[39:0], din_q};
        type_word = {hdr[7:0], din_q};
        crc_next  = crc_byte(crc, din_q);
        // The reflected register holds the bit-reversed residue after the FCS.
        frame_bad = (bit_rev(crc) != CRC_RESIDUE) || er_seen ||
                    (len < MIN_L) || (len > max_len);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            din_q        <= 8'h00;
            // dv history resets high so a frame already in progress at reset
            // release does not look like a start edge.
            dv_q         <= 1'b1;
            dv_prev      <= 1'b1;
            er_q         <= 1'b0;
            crc          <= 32'hFFFFFFFF;
            len          <= 14'd0;
            hdr          <= 40'd0;
            dl           <= '0;
            dl_cnt       <= 3'd0;
            sof_pend     <= 1'b0;
            er_seen      <= 1'b0;
            rxd_data     <= 8'h00;
            rxd_valid    <= 1'b0;
            rxd_sof      <= 1'b0;
            rxd_eof      <= 1'b0;
            rxd_err      <= 1'b0;
            rx_count     <= 32'd0;
            rx_err_count <= 32'd0;
        end else begin
            din_q     <= int_rx_din;
            dv_q      <= int_rx_dv;
            er_q      <= int_rx_er;
            dv_prev   <= dv_q;
            rxd_valid <= 1'b0;
            rxd_sof   <= 1'b0;
            rxd_eof   <= 1'b0;
            rxd_err   <= 1'b0;

            case (state)
                IDLE: begin
                    if (dv_q && !dv_prev) begin
                        er_seen <= er_q;
                        if (din_q == 8'h55) begin
                            state <= PREAMBLE;
                        end else if (din_q == 8'hD5) begin
                            state <= HEADER;
                            crc   <= 32'hFFFFFFFF;
                            len   <= 14'd0;
                        end else begin
                            state <= DROP;
                        end
                    end
                end
                PREAMBLE: begin
                    if (!dv_q) begin
                        state <= IDLE;
                    end else begin
                        er_seen <= er_seen | er_q;
                        if (din_q == 8'hD5) begin
                            state <= HEADER;
                            crc   <= 32'hFFFFFFFF;
                            len   <= 14'd0;
                        end else if (din_q != 8'h55) begin
                            state <= DROP;
                        end
                    end
                end
                HEADER: begin
                    if (!dv_q) begin
                        state <= IDLE;
                    end else begin
                        crc     <= crc_next;
                        len     <= len_next;
                        hdr     <= {hdr[31:0], din_q};
                        er_seen <= er_seen | er_q;
                        if (len == 14'd5) begin
                            if (!promiscuous && dst_word != local_mac_addr &&
                                dst_word != 48'hFFFF_FFFF_FFFF)
                                state <= DROP;
                        end else if (len == 14'd13) begin
                            if (type_word == ethertype) begin
                                state    <= PAYLOAD;
                                dl_cnt   <= 3'd0;
                                sof_pend <= 1'b1;
                            end else begin
                                state <= DROP;
                            end
                        end
                    end
                end
                PAYLOAD: begin
                    if (!dv_q) begin
                        // Last four bytes in the delay line are the FCS; discard them.
                        rxd_eof <= 1'b1;
                        rxd_err <= frame_bad;
                        if (frame_bad) rx_err_count <= rx_err_count + 32'd1;
                        else           rx_count     <= rx_count + 32'd1;
                        dl_cnt  <= 3'd0;
                        state   <= IDLE;
                    end else begin
                        crc     <= crc_next;
                        len     <= len_next;
                        er_seen <= er_seen | er_q;
                        dl      <= {dl[2:0], din_q};
                        if (dl_cnt == 3'd4) begin
                            if (len_next <= max_len) begin
                                rxd_valid <= 1'b1;
                                rxd_data  <= dl[3];
                                rxd_sof   <= sof_pend;
                                sof_pend  <= 1'b0;
                            end
                        end else begin
                            dl_cnt <= dl_cnt + 3'd1;
                        end
                    end
                end
                DROP: begin
                    if (!dv_q) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_engine_stream.sv
// tb/tb_rx_engine_stream.sv - scoreboard testbench for rx_engine_stream
module tb_rx_engine_stream;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [47:0] local_mac_addr;
    logic [15:0] ethertype;
    logic        promiscuous;
    logic        jumboframes;
    logic [7:0]  int_rx_din;
    logic        int_rx_dv;
    logic        int_rx_er;
    logic [7:0]  rxd_data;
    logic        rxd_valid;
    logic        rxd_sof;
    logic        rxd_eof;
    logic        rxd_err;
    logic [31:0] rx_count;
    logic [31:0] rx_err_count;

    always #5 clk = ~clk;

    rx_engine_stream dut (
        .clk(clk), .reset_n(reset_n),
        .local_mac_addr(local_mac_addr), .ethertype(ethertype),
        .promiscuous(promiscuous), .jumboframes(jumboframes),
        .int_rx_din(int_rx_din), .int_rx_dv(int_rx_dv), .int_rx_er(int_rx_er),
        .rxd_data(rxd_data), .rxd_valid(rxd_valid), .rxd_sof(rxd_sof),
        .rxd_eof(rxd_eof), .rxd_err(rxd_err),
        .rx_count(rx_count), .rx_err_count(rx_err_count)
    );

    typedef struct {
        logic       eof;
        logic [7:0] data;
        logic       sof;
        logic       err;
    } beat_t;

    beat_t       exp_q[$];
    logic [7:0]  frm[$];
    int          checks = 0;
    int          passes = 0;
    logic        mon_off = 1'b0;
    int unsigned exp_rx = 0;
    int unsigned exp_err = 0;

    localparam logic [47:0] LOCAL = 48'h02_11_22_33_44_55;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [15:0] ETYPE = 16'h88B5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Frame bytes dst..FCS in frm.
    task automatic build(input logic [47:0] dst, input int npay, input logic bad_fcs);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(8'(8'hA0 + i));
        frm.push_back(ETYPE[15:8]);
        frm.push_back(ETYPE[7:0]);
        for (int i = 0; i < npay; i++) frm.push_back(8'(i));
        c = 32'hFFFFFFFF;
        foreach (frm[i]) c = crc_upd(c, frm[i]);
        c = ~c;
        frm.push_back(c[7:0]);
        frm.push_back(c[15:8]);
        frm.push_back(c[23:16]);
        frm.push_back(bad_fcs ? (c[31:24] ^ 8'h01) : c[31:24]);
    endtask

    task automatic drive(input logic [7:0] b, input logic dv, input logic er);
        @(negedge clk);
        int_rx_din = b;
        int_rx_dv  = dv;
        int_rx_er  = er;
    endtask

    task automatic send(input int er_idx);
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        foreach (frm[i]) drive(frm[i], 1'b1, (i == er_idx));
        for (int i = 0; i < 12; i++) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic expect_frame(input int nemit, input logic err);
        beat_t b;
        for (int i = 0; i < nemit; i++) begin
            b.eof = 1'b0; b.data = frm[14+i]; b.sof = (i == 0); b.err = 1'b0;
            exp_q.push_back(b);
        end
        b.eof = 1'b1; b.data = 8'h00; b.sof = 1'b0; b.err = err;
        exp_q.push_back(b);
        if (err) exp_err++;
        else     exp_rx++;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_rx_count"}, rx_count, exp_rx);
        check({tag, "_rx_err_count"}, rx_err_count, exp_err);
    endtask

    // Monitor: compares every presented beat against the scoreboard queue.
    always @(negedge clk) begin
        beat_t b;
        if (reset_n && !mon_off && (rxd_valid || rxd_eof)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {30'd0, rxd_eof, rxd_valid}, 32'd0);
            end else begin
                b = exp_q.pop_front();
                check("beat_kind", {31'd0, rxd_eof}, {31'd0, b.eof});
                if (b.eof) begin
                    check("eof_err", {31'd0, rxd_err}, {31'd0, b.err});
                    check("eof_no_valid", {31'd0, rxd_valid}, 32'd0);
                end else begin
                    check("data", {24'd0, rxd_data}, {24'd0, b.data});
                    check("sof", {31'd0, rxd_sof}, {31'd0, b.sof});
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        local_mac_addr = LOCAL;
        ethertype = ETYPE;
        promiscuous = 1'b0;
        jumboframes = 1'b0;
        int_rx_din = 8'h00;
        int_rx_dv = 1'b0;
        int_rx_er = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, rxd_valid}, 32'd0);
        check("rst_eof", {31'd0, rxd_eof}, 32'd0);
        check("rst_data", {24'd0, rxd_data}, 32'd0);
        check_counters("rst");
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Good frame, 46 payload bytes (64-byte frame).
        build(LOCAL, 46, 1'b0); expect_frame(46, 1'b0); send(-1);
        check_counters("good");

        // Corrupted FCS.
        build(LOCAL, 46, 1'b1); expect_frame(46, 1'b1); send(-1);
        check_counters("bad_fcs");

        // Foreign destination, not promiscuous: silent drop.
        build(OTHER, 46, 1'b0); send(-1);
        check_counters("foreign");

        // Foreign destination, promiscuous.
        promiscuous = 1'b1;
        build(OTHER, 46, 1'b0); expect_frame(46, 1'b0); send(-1);
        check_counters("promisc");
        promiscuous = 1'b0;

        // Broadcast.
        build(BCAST, 46, 1'b0); expect_frame(46, 1'b0); send(-1);
        check_counters("bcast");

        // Receive error on payload byte 10 (frame index 14+10).
        build(LOCAL, 46, 1'b0); expect_frame(46, 1'b1); send(24);
        check_counters("rx_er");

        // 1519-byte frame: standard limit stops output after 1500 bytes.
        build(LOCAL, 1501, 1'b0); expect_frame(1500, 1'b1); send(-1);
        check_counters("oversize");

        jumboframes = 1'b1;
        build(LOCAL, 1501, 1'b0); expect_frame(1501, 1'b0); send(-1);
        check_counters("jumbo");
        jumboframes = 1'b0;

        // Reset in the middle of a payload with dv held high.
        build(LOCAL, 46, 1'b0);
        mon_off = 1'b1;
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) drive(frm[i], 1'b1, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, rxd_valid}, 32'd0);
        check("midrst_sof", {31'd0, rxd_sof}, 32'd0);
        check("midrst_eof", {31'd0, rxd_eof}, 32'd0);
        check("midrst_err", {31'd0, rxd_err}, 32'd0);
        check("midrst_data", {24'd0, rxd_data}, 32'd0);
        exp_rx = 0;
        exp_err = 0;
        check_counters("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        mon_off = 1'b0;
        for (int i = 40; i < frm.size(); i++) drive(frm[i], 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) drive(8'h00, 1'b0, 1'b0);
        check_counters("after_rst_tail");

        build(LOCAL, 46, 1'b0); expect_frame(46, 1'b0); send(-1);
        check_counters("after_rst_good");

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rx_engine_stream.md
Name: rx_engine_stream

Overview:
- Receive-side counterpart of the streaming Ethernet transmit engine.
- Accepts the byte stream from the reconciliation layer and strips preamble/SFD.
- Filters on destination MAC and ethertype, checks FCS (CRC-32), and delivers the payload as a byte stream.
- Ends each accepted frame with a one-cycle status beat; maintains good/bad frame counters.

Parameters:
- MAX_STD, 1518, max frame length (dst..FCS, bytes) when jumboframes=0
- MAX_JUMBO, 9018, max frame length when jumboframes=1
- MIN_LEN, 64, min frame length (dst..FCS)

Ports:
- clk  in  1  receive byte clock (int_rx_clk domain); all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- local_mac_addr  in  48  accepted unicast destination
- ethertype  in  16  accepted ethertype
- promiscuous  in  1  1 = accept any destination
- jumboframes  in  1  selects MAX_JUMBO limit
- int_rx_din  in  8  received byte
- int_rx_dv  in  1  data valid from reconciliation layer
- int_rx_er  in  1  receive error from reconciliation layer
- rxd_data  out  8  payload byte
- rxd_valid  out  1  rxd_data valid this cycle
- rxd_sof  out  1  with rxd_valid: first payload byte
- rxd_eof  out  1  status beat, one cycle, rxd_valid=0
- rxd_err  out  1  valid with rxd_eof: 1 = frame bad
- rx_count  out  32  good frames received
- rx_err_count  out  32  bad (accepted-address) frames

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE, CRC reg all-ones, delay line empty.
- Inputs are registered once; "sample" means the registered values.
- IDLE: start only on a dv 0->1 edge. This discards a frame already in progress at reset release.
  - First byte 0x55 -> PREAMBLE.
  - First byte 0xD5 -> HEADER.
  - Any other first byte -> DROP.
- PREAMBLE: 0x55 stays; 0xD5 -> HEADER (CRC init, byte counter 0); any other byte -> DROP. More than 7 consecutive 0x55 is permitted.
- HEADER: 14 bytes (dst 6, src 6, ethertype 2, big-endian on wire), all fed to CRC.
  - After byte 6: dst must equal local_mac_addr or FF:FF:FF:FF:FF:FF, unless promiscuous=1.
  - After byte 14: type must equal ethertype.
  - Mismatch -> DROP: silent, no rxd_eof, no counter change.
  - Both match -> PAYLOAD.
- PAYLOAD: every byte goes to CRC and into a 4-byte delay line.
  - A byte leaves the delay line (rxd_valid=1) only when a 5th byte behind it has been sampled, so the FCS is never output.
  - Latency: payload byte N is presented the cycle after byte N+4 is sampled.
  - rxd_sof on the first emitted byte.
- Frame end (sample with dv=0 in HEADER-accepted/PAYLOAD): next cycle rxd_eof=1, then IDLE; the delay line is flushed without output. rxd_err = OR of:
  - CRC residue != 0xC704DD7B
  - int_rx_er seen at any byte of the frame
  - length (dst..FCS) < MIN_LEN
  - length > max
- dv dropping during HEADER before the address/type decision -> silent drop.
- dv dropping after the decision with fewer than 4 payload bytes -> rxd_eof with rxd_err=1.
- Length: 14-bit byte counter, saturating. Once it exceeds the limit, rxd_valid is suppressed for the rest of the frame; the error is reported at end.
- CRC: reflected CRC-32, poly 0x04C11DB7, LSB-first per byte, init all-ones, 8-bit parallel update.
- Counters: rx_count +1 on eof with err=0; rx_err_count +1 on eof with err=1. Both wrap at 2^32.
- DROP: ignore bytes until dv=0, then IDLE.
- int_rx_er while dv=0 is ignored.
- dv re-asserting in the same cycle as the status beat is not a start edge. Minimum inter-frame gap is 1 idle sample.

Test Plan:
- Good frame: 7x55, D5, dst=local, ethertype match, 46 payload bytes 0x00..0x2D, correct FCS -> 46 rxd_valid beats in order, sof on 0x00, then rxd_eof with rxd_err=0; rx_count=1.
- Same frame, last FCS byte XOR 0x01 -> identical 46 bytes, rxd_err=1; rx_err_count=1, rx_count unchanged.
- dst=02:00:00:00:00:01 != local with promiscuous=0 -> no rxd_valid, no eof, counters unchanged. Repeat with promiscuous=1 -> delivered. Broadcast dst -> delivered.
- int_rx_er pulsed on payload byte 10 -> all bytes delivered, rxd_err=1.
- 1519-byte frame, jumboframes=0 -> output stops at the limit, rxd_err=1. Same frame with jumboframes=1 -> rxd_err=0.
- reset_n asserted mid-payload with dv held high -> outputs 0 immediately; rest of that frame ignored; next frame after dv low is received normally.
